// File: rtl/modn_seq.sv
// Sequential restoring shift-subtract modular reduction: remainder and quotient of din / m, UNROLL bits per clock.
// Optional `MODN_EARLY_EXIT_EN` skips leading-zero groups of the dividend to shorten latency.
module modn_seq #(
  parameter int WIDTH  = 64,
  parameter int UNROLL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] m,
  output logic             rdy,
  output logic [WIDTH-1:0] mod_out,
  output logic [WIDTH-1:0] quot,
  output logic             dz
);

  localparam int N  = WIDTH / UNROLL;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_din;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_quot;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH:0]   w_rem;
  logic [WIDTH-1:0] w_din;
  logic [WIDTH-1:0] w_quot;
  logic [WIDTH-1:0] w_start_din;
  logic [CW-1:0]    w_start_cnt;

  // One clock's worth of restoring steps, MSB of the shifted dividend first.
  always_comb begin
    // NOTE: blocking assignments here chain UNROLL steps combinationally within one clock.
    w_rem  = r_rem;
    w_din  = r_din;
    w_quot = r_quot;
    for (int i = 0; i < UNROLL; i++) begin
      w_rem = {w_rem[WIDTH-1:0], w_din[WIDTH-1]};
      w_din = {w_din[WIDTH-2:0], 1'b0};
      if (w_rem >= {1'b0, r_m}) begin
        w_rem  = w_rem - {1'b0, r_m};
        w_quot = {w_quot[WIDTH-2:0], 1'b1};
      end else begin
        w_quot = {w_quot[WIDTH-2:0], 1'b0};
      end
    end
  end

`ifdef MODN_EARLY_EXIT_EN
  int   w_lz;
  logic w_found;

  always_comb begin
    w_lz    = 0;
    w_found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!w_found) begin
        if (din[i]) w_found = 1'b1;
        else        w_lz    = w_lz + 1;
      end
    end
    w_start_din = din << ((w_lz / UNROLL) * UNROLL);
    w_start_cnt = CW'(N - (w_lz / UNROLL));
  end
`else
  assign w_start_din = din;
  assign w_start_cnt = CW'(N);
`endif

  // Control and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      rdy     <= 1'b1;
      mod_out <= '0;
      quot    <= '0;
      dz      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (en) begin
            if (m == '0) begin
              mod_out <= din;
              quot    <= '0;
              dz      <= 1'b1;
              rdy     <= 1'b1;
              r_state <= S_DONE;
            end else if (w_start_cnt == '0) begin
              mod_out <= '0;
              quot    <= '0;
              dz      <= 1'b0;
              rdy     <= 1'b1;
              r_state <= S_DONE;
            end else begin
              rdy     <= 1'b0;
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (r_cnt == CW'(1)) begin
            mod_out <= w_rem[WIDTH-1:0];
            quot    <= w_quot;
            dz      <= 1'b0;
            rdy     <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (!en) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: working registers are always loaded at the start edge before use, so they carry no reset.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && en) begin
      r_din  <= w_start_din;
      r_m    <= m;
      r_rem  <= '0;
      r_quot <= '0;
      r_cnt  <= w_start_cnt;
    end else if (r_state == S_RUN) begin
      r_din  <= w_din;
      r_rem  <= w_rem;
      r_quot <= w_quot;
      r_cnt  <= r_cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_modn_seq.sv
// Directed bench for modn_seq: a 64-bit UNROLL=1 instance driven from a vector table,
// plus a 32-bit UNROLL=4 instance and hand-written en-hold and mid-run reset sequences.
module tb_modn_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        en64, rdy64, dz64;
  logic [63:0] din64, m64, mod64, quot64;
  logic        en32, rdy32, dz32;
  logic [31:0] din32, m32, mod32, quot32;

  modn_seq #(.WIDTH(64), .UNROLL(1)) u_dut64 (
    .clk(clk), .rst(rst), .en(en64), .din(din64), .m(m64),
    .rdy(rdy64), .mod_out(mod64), .quot(quot64), .dz(dz64)
  );

  modn_seq #(.WIDTH(32), .UNROLL(4)) u_dut32 (
    .clk(clk), .rst(rst), .en(en32), .din(din32), .m(m32),
    .rdy(rdy32), .mod_out(mod32), .quot(quot32), .dz(dz32)
  );

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Cycles rdy stays low for one operation.
  function automatic int exp_lat(input logic [63:0] d, input logic [63:0] mm, input int w, input int u);
`ifdef MODN_EARLY_EXIT_EN
    int bl;
`endif
    if (mm == 64'd0) return 0;
`ifdef MODN_EARLY_EXIT_EN
    bl = 0;
    for (int i = 0; i < w; i++) if (d[i]) bl = i + 1;
    return w / u - (w - bl) / u;
`else
    return w / u;
`endif
  endfunction

  // One full operation on the 64-bit instance; inputs are scrambled right after the start edge.
  task automatic run64(input logic [63:0] d, input logic [63:0] mm, output int lat,
                       output logic [63:0] first_mod, output logic [63:0] first_quot,
                       output logic first_dz);
    @(negedge clk); en64 = 1'b0;
    @(negedge clk); din64 = d; m64 = mm; en64 = 1'b1;
    @(negedge clk); en64 = 1'b0; din64 = ~d; m64 = ~mm;
    first_mod = mod64; first_quot = quot64; first_dz = dz64;
    lat = 0;
    while (rdy64 !== 1'b1 && lat < 300) begin
      lat++;
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [63:0] din;
    logic [63:0] m;
    logic [63:0] exp_mod;
    logic [63:0] exp_quot;
    logic        exp_dz;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, el, k;
    logic [63:0] fm, fq, pm, pq;
    logic        fdz, pdz;

    vecs[0]  = '{64'd100,        64'd110,        64'd100,        64'd0,    1'b0};
    vecs[1]  = '{64'd859770326,  64'd826537,     64'd171846,     64'd1040, 1'b0};
    vecs[2]  = '{'1,             '1,             64'd0,          64'd1,    1'b0};
    vecs[3]  = '{64'd7970024,    64'd0,          64'd7970024,    64'd0,    1'b1};
    vecs[4]  = '{64'd101,        64'd11,         64'd2,          64'd9,    1'b0};
    vecs[5]  = '{64'd5,          64'd3,          64'd2,          64'd1,    1'b0};
    vecs[6]  = '{64'd0,          64'd7,          64'd0,          64'd0,    1'b0};
    vecs[7]  = '{64'd0,          64'd0,          64'd0,          64'd0,    1'b1};
    vecs[8]  = '{'1,             64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0};
    vecs[9]  = '{64'h8000_0000_0000_0000, 64'd3, 64'd2, 64'd3074457345618258602, 1'b0};
    vecs[10] = '{64'hFFFF_FFFF_FFFF_FFFE, '1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 1'b0};
    vecs[11] = '{64'd1000,       64'd7,          64'd6,          64'd142,  1'b0};

    rst = 1'b1; en64 = 1'b0; din64 = '0; m64 = '0; en32 = 1'b0; din32 = '0; m32 = '0;
    repeat (2) @(negedge clk);
    check("reset rdy64", {63'd0, rdy64}, 64'd1);
    check("reset mod64", mod64, 64'd0);
    check("reset quot64", quot64, 64'd0);
    check("reset dz64", {63'd0, dz64}, 64'd0);
    check("reset rdy32", {63'd0, rdy32}, 64'd1);
    rst = 1'b0;

    // 32-bit / UNROLL=4: en held high through DONE must not restart.
    @(negedge clk); din32 = 32'd202; m32 = 32'd33; en32 = 1'b1;
    @(negedge clk); din32 = 32'd1000; m32 = 32'd3;
    lat = 0;
    while (rdy32 !== 1'b1 && lat < 100) begin
      lat++;
      @(negedge clk);
    end
    check("u32 latency", 64'(lat), 64'(exp_lat(64'd202, 64'd33, 32, 4)));
    check("u32 mod", {32'd0, mod32}, 64'd4);
    check("u32 quot", {32'd0, quot32}, 64'd6);
    check("u32 dz", {63'd0, dz32}, 64'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("u32 hold%0d rdy", c), {63'd0, rdy32}, 64'd1);
      check($sformatf("u32 hold%0d mod", c), {32'd0, mod32}, 64'd4);
      check($sformatf("u32 hold%0d quot", c), {32'd0, quot32}, 64'd6);
    end
    en32 = 1'b0;

    // 64-bit vector table.
    pm = 64'd0; pq = 64'd0; pdz = 1'b0;
    for (int i = 0; i < 12; i++) begin
      run64(vecs[i].din, vecs[i].m, lat, fm, fq, fdz);
      el = exp_lat(vecs[i].din, vecs[i].m, 64, 1);
      if (el > 0) begin
        check($sformatf("v%0d hold mod", i), fm, pm);
        check($sformatf("v%0d hold quot", i), fq, pq);
        check($sformatf("v%0d hold dz", i), {63'd0, fdz}, {63'd0, pdz});
      end
      check($sformatf("v%0d latency", i), 64'(lat), 64'(el));
      check($sformatf("v%0d mod", i), mod64, vecs[i].exp_mod);
      check($sformatf("v%0d quot", i), quot64, vecs[i].exp_quot);
      check($sformatf("v%0d dz", i), {63'd0, dz64}, {63'd0, vecs[i].exp_dz});
      pm = vecs[i].exp_mod; pq = vecs[i].exp_quot; pdz = vecs[i].exp_dz;
    end

    // Asynchronous reset in the middle of a run.
    el = exp_lat(64'd555, 64'd999999, 64, 1);
    k  = (el > 10) ? 10 : el / 2;
    @(negedge clk); en64 = 1'b0;
    @(negedge clk); din64 = 64'd555; m64 = 64'd999999; en64 = 1'b1;
    @(negedge clk); en64 = 1'b0;
    repeat (k - 1) @(negedge clk);
    check("pre-abort rdy", {63'd0, rdy64}, 64'd0);
    #2 rst = 1'b1;
    #1;
    check("abort rdy", {63'd0, rdy64}, 64'd1);
    check("abort mod", mod64, 64'd0);
    check("abort quot", quot64, 64'd0);
    check("abort dz", {63'd0, dz64}, 64'd0);
    check("abort mod32", {32'd0, mod32}, 64'd0);
    @(negedge clk); rst = 1'b0;

    run64(64'd555, 64'd999999, lat, fm, fq, fdz);
    check("fresh latency", 64'(lat), 64'(el));
    check("fresh mod", mod64, 64'd555);
    check("fresh quot", quot64, 64'd0);
    check("fresh dz", {63'd0, dz64}, 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/modn_seq.md
# modn_seq

Parametrised sequential modular-reduction unit: computes din mod m, plus the quotient, by restoring shift-subtract, UNROLL quotient bits per clock. It generalises the fixed 64-bit mod64 unit to any operand width and throughput, adds a quotient output and a divide-by-zero flag, and keeps the same en/rdy level handshake. It sits beside mod64 in the arithmetic datapath and is the drop-in for new users.

## Interface
- WIDTH, 64: operand, quotient and remainder width; ≥ 2.
- UNROLL, 1: quotient bits resolved per clock; 1, 2 or 4; WIDTH % UNROLL == 0.
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- en  in  1  request, level; sampled only in IDLE.
- din  in  WIDTH  dividend, sampled at the start edge.
- m  in  WIDTH  modulus, sampled at the start edge.
- rdy  out  1  1 = idle or result valid; 0 = busy.
- mod_out  out  WIDTH  remainder din mod m.
- quot  out  WIDTH  quotient din / m.
- dz  out  1  last completed operation had m == 0.

## Operation
- States: IDLE, RUN, DONE. Reset enters IDLE.
- IDLE, en = 1 at an edge (the start edge):
  - Capture din and m.
  - Clear the (WIDTH+1)-bit partial remainder and the quotient register.
  - Load the iteration counter with N = WIDTH/UNROLL.
  - Set rdy to 0 and go to RUN.
- Start edge with m == 0:
  - Go straight to DONE.
  - mod_out = din, quot = 0, dz = 1, rdy = 1.
- RUN, each edge: repeat UNROLL times, MSB first:
  - rem = (rem << 1) | next din bit.
  - If rem ≥ m: rem = rem − m and the quotient bit is 1; otherwise the quotient bit is 0.
  - Decrement the counter.
- RUN, edge that processes the final group:
  - Write mod_out = rem[WIDTH-1:0], quot, and dz = 0.
  - Set rdy to 1 and go to DONE.
- The remainder datapath is WIDTH+1 bits, so it cannot overflow at m ≥ 2^(WIDTH-1).
- DONE: outputs hold. en = 0 at an edge returns the block to IDLE with rdy still 1.
- A new operation needs en low for at least one edge after completion. en held high in DONE does not restart the block.
- en falling during RUN is ignored; the operation completes.
- din or m changing after the start edge has no effect.
- mod_out, quot and dz change only on completion. They keep the previous result during RUN.
- rst asserted at any time, mid-RUN included: abort immediately and go to IDLE. All outputs take their reset values.

## Timing
- Reset values: rdy = 1, mod_out = 0, quot = 0, dz = 0, state IDLE.
- Latency, m ≠ 0: the start edge is E0. rdy is 0 after E0 and returns to 1 after edge E_N, with results valid at the same edge. rdy is low for exactly N cycles.
- Latency, m == 0: rdy is 1 again after E0. rdy may show no low cycle.
- Throughput: one operation per N+2 cycles minimum, including the en-low cycle.
- All outputs are registered; there is no combinational path from din, m or en to any output.

## Configuration
- MODN_EARLY_EXIT_EN undefined:
  - The iteration count is always N = WIDTH/UNROLL.
- MODN_EARLY_EXIT_EN defined:
  - At the start edge, count the leading zero bits of din and round the count down to a multiple of UNROLL (call it L).
  - Pre-shift din by L and load the counter with N − L/UNROLL.
  - din == 0 with m ≠ 0 gives a count of 0. The block goes directly to DONE with mod_out = 0, quot = 0, and rdy is 1 after E0.
  - Results are bit-identical to the undefined build; only latency changes.

## Test plan
- WIDTH = 64, UNROLL = 1: din = 100, m = 110 → mod_out = 100, quot = 0, dz = 0; rdy low for exactly 64 cycles.
- WIDTH = 64, UNROLL = 1: din = 859770326, m = 826537 → mod_out = 171846, quot = 1040. Then din = 2^64−1, m = 2^64−1 → mod_out = 0, quot = 1 (exercises the WIDTH+1 remainder path).
- din = 7970024, m = 0 → mod_out = 7970024, quot = 0, dz = 1; rdy is 1 one edge after start. The following op (101, 11) → mod_out = 2, quot = 9, dz = 0.
- WIDTH = 32, UNROLL = 4: din = 202, m = 33 → mod_out = 4, quot = 6; rdy low for 8 cycles. en held high through DONE for 5 cycles → no restart, outputs stable.
- MODN_EARLY_EXIT_EN, WIDTH = 64, UNROLL = 1: din = 5, m = 3 → mod_out = 2, quot = 1; rdy low for 3 cycles. din = 0, m = 7 → mod_out = 0, rdy is 1 after the start edge.
- Assert rst for 1 cycle at the 10th RUN cycle of (555, 999999) → rdy = 1 and mod_out, quot, dz = 0 immediately (asynchronous). A fresh (555, 999999) afterwards → mod_out = 555, quot = 0.
